clkdiv_bank: RTL and testbench

//  N-channel programmable clock divider / clock-enable generator, one shared input clock.
//  Per channel: runtime divisor, toggle (50% duty) or single-cycle pulse mode, enable.

---
 rtl/clkdiv_pkg.sv | 15 +
 rtl/clkdiv_chan.sv | 112 +++++++++++
 rtl/clkdiv_bank.sv | 76 +++++++
 tb/tb_clkdiv_bank.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the clock divider bank.
// The output mode type and its idle output level.
package clkdiv_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } clkdiv_mode_e;

  // Level a channel rests at when disabled, synced or just reset.
  function automatic logic idle_level(input clkdiv_mode_e mode);
    return (mode == MODE_TOGGLE);
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: wrap counter, active threshold/mode and a one-deep pending config
// that is applied only at a period boundary so the output never shows a runt phase.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int DIV_W        = 16,
  parameter int DEFAULT_DIV  = 1,
  parameter int DEFAULT_MODE = 0
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_in,
  input  logic             cfg_acc,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEFAULT_DIV);
  localparam clkdiv_mode_e     RST_MODE = (DEFAULT_MODE != 0) ? MODE_PULSE : MODE_TOGGLE;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] thr_q, thr_d;
  logic [DIV_W-1:0] pdiv_q, pdiv_d;
  clkdiv_mode_e     mode_q, mode_d;
  clkdiv_mode_e     pmode_q, pmode_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             out_q, out_d;
  logic             wrap;

  assign wrap = (cnt_q >= thr_q);

  always_comb begin
    cnt_d   = cnt_q;
    thr_d   = thr_q;
    mode_d  = mode_q;
    pdiv_d  = pdiv_q;
    pmode_d = pmode_q;
    pend_d  = pend_q;
    tick_d  = 1'b0;
    out_d   = out_q;

    if (!en) begin
      // A stopped channel has no period boundary to wait for, so apply at once.
      cnt_d = '0;
      if (pend_q) begin
        thr_d  = pdiv_q;
        mode_d = pmode_q;
        pend_d = 1'b0;
      end
      out_d = idle_level(mode_d);
    end else if (sync_in) begin
      cnt_d = '0;
      out_d = idle_level(mode_q);
    end else if (wrap) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      out_d  = (mode_q == MODE_TOGGLE) ? ~out_q : 1'b1;
      if (pend_q) begin
        thr_d  = pdiv_q;
        pend_d = 1'b0;
        if (pmode_q != mode_q) begin
          mode_d = pmode_q;
          out_d  = idle_level(pmode_q);
        end
      end
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
      if (mode_q == MODE_PULSE) begin
        out_d = 1'b0;
      end
    end

    // Accept is only offered while nothing is pending, so it never races an apply.
    if (cfg_acc) begin
      pend_d  = 1'b1;
      pdiv_d  = cfg_div;
      pmode_d = clkdiv_mode_e'(cfg_mode);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q   <= '0;
      thr_q   <= RST_DIV;
      mode_q  <= RST_MODE;
      pdiv_q  <= RST_DIV;
      pmode_q <= RST_MODE;
      pend_q  <= 1'b0;
      tick_q  <= 1'b0;
      out_q   <= idle_level(RST_MODE);
    end else begin
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      mode_q  <= mode_d;
      pdiv_q  <= pdiv_d;
      pmode_q <= pmode_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
      out_q   <= out_d;
    end
  end

  assign clk_out = out_q;
  assign tick    = tick_q;
  assign pend    = pend_q;

endmodule

// File: rtl/clkdiv_bank.sv
// N-channel programmable clock divider / clock-enable generator with a shared
// valid/ready config port and a global phase-align strobe.
module clkdiv_bank
  import clkdiv_pkg::*;
#(
  parameter  int N_CH         = 4,
  parameter  int DIV_W        = 16,
  parameter  int DEFAULT_DIV  = 1,
  parameter  int DEFAULT_MODE = 0,
  localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             sync_in,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_chan,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic             cfg_err,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pend
);

  logic [N_CH-1:0] sel;
  logic [N_CH-1:0] acc;
  logic            in_range;
  logic            sel_pend;
  logic            xfer;
  logic            cfg_err_q, cfg_err_d;

  // Decoded select is all-zero for an out-of-range channel, which reads as ready.
  assign in_range  = |sel;
  assign sel_pend  = |(sel & pend);
  assign cfg_ready = rst | ~sel_pend;
  assign xfer      = cfg_valid & cfg_ready;
  assign acc       = sel & {N_CH{xfer}};

  always_comb begin
    cfg_err_d = xfer & ~in_range;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign sel[gi] = (cfg_chan == CH_W'(gi));

    clkdiv_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .DEFAULT_MODE(DEFAULT_MODE)
    ) u_chan (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en[gi]),
      .sync_in (sync_in),
      .cfg_acc (acc[gi]),
      .cfg_div (cfg_div),
      .cfg_mode(cfg_mode),
      .clk_out (clk_out[gi]),
      .tick    (tick[gi]),
      .pend    (pend[gi])
    );
  end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Self-checking bench for clkdiv_bank: directed scenarios plus a randomized run,
// all compared against a period/parity-based behavioural model.
module tb_clkdiv_bank;
  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int CW  = 2;

  logic           clk_in = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] en = '0;
  logic           sync_in = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_chan = '0;
  logic [DW-1:0]  cfg_div = '0;
  logic           cfg_mode = 1'b0;
  logic           cfg_err;
  logic [NCH-1:0] clk_out, tick, pend;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  clkdiv_bank #(
    .N_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(1), .DEFAULT_MODE(0)
  ) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .sync_in(sync_in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_err(cfg_err),
    .clk_out(clk_out), .tick(tick), .pend(pend)
  );

  // Reference model: elapsed cycles in the current period, wraps since the last
  // idle point (toggle level is its parity), and a one-entry pending config.
  int m_t[NCH], m_pdiv[NCH], m_elapsed[NCH], m_wraps[NCH];
  bit m_pulse[NCH], m_ppulse[NCH], m_pend[NCH], m_tick[NCH], m_out[NCH];
  bit m_err;
  int m_ch;
  bit m_rdy;

  always @(posedge clk_in) begin
    m_ch  = int'(cfg_chan);
    m_rdy = (m_ch >= NCH) || !m_pend[m_ch];
    if (rst) begin
      m_err = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_t[i] = 1; m_pulse[i] = 1'b0; m_pend[i] = 1'b0; m_tick[i] = 1'b0;
        m_elapsed[i] = 0; m_wraps[i] = 0; m_out[i] = 1'b1;
      end
    end else begin
      m_err = cfg_valid && (m_ch >= NCH);
      for (int i = 0; i < NCH; i++) begin
        bit changed;
        changed = 1'b0;
        m_tick[i] = 1'b0;
        if (!en[i]) begin
          m_elapsed[i] = 0; m_wraps[i] = 0;
          if (m_pend[i]) begin
            m_t[i] = m_pdiv[i]; m_pulse[i] = m_ppulse[i]; m_pend[i] = 1'b0;
          end
          m_out[i] = !m_pulse[i];
        end else if (sync_in) begin
          m_elapsed[i] = 0; m_wraps[i] = 0; m_out[i] = !m_pulse[i];
        end else if (m_elapsed[i] == m_t[i]) begin
          m_elapsed[i] = 0; m_tick[i] = 1'b1;
          if (m_pend[i]) begin
            m_t[i] = m_pdiv[i]; m_pend[i] = 1'b0;
            if (m_ppulse[i] != m_pulse[i]) begin
              m_pulse[i] = m_ppulse[i]; changed = 1'b1;
            end
          end
          if (changed) begin
            m_wraps[i] = 0; m_out[i] = !m_pulse[i];
          end else if (!m_pulse[i]) begin
            m_wraps[i]++; m_out[i] = (m_wraps[i] % 2 == 0);
          end else begin
            m_out[i] = 1'b1;
          end
        end else begin
          m_elapsed[i]++;
          m_out[i] = m_pulse[i] ? 1'b0 : (m_wraps[i] % 2 == 0);
        end
        if (cfg_valid && m_rdy && (m_ch == i)) begin
          m_pend[i] = 1'b1; m_pdiv[i] = int'(cfg_div); m_ppulse[i] = cfg_mode;
        end
      end
    end
  end

  function automatic logic [NCH-1:0] exp_out();
    for (int i = 0; i < NCH; i++) exp_out[i] = m_out[i];
  endfunction
  function automatic logic [NCH-1:0] exp_tick();
    for (int i = 0; i < NCH; i++) exp_tick[i] = m_tick[i];
  endfunction
  function automatic logic [NCH-1:0] exp_pend();
    for (int i = 0; i < NCH; i++) exp_pend[i] = m_pend[i];
  endfunction
  function automatic logic exp_ready();
    if (rst || int'(cfg_chan) >= NCH) return 1'b1;
    return !m_pend[int'(cfg_chan)];
  endfunction

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = '0;
    cyc(); cyc();
    n_checks++;
    if (clk_out !== 3'b111) begin n_errors++; $display("FAIL reset_clk_out got=%b exp=111", clk_out); end
    n_checks++;
    if (tick !== 3'b000 || pend !== 3'b000) begin
      n_errors++; $display("FAIL reset_tick_pend tick=%b pend=%b exp=000/000", tick, pend);
    end
    n_checks++;
    if (cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin
      n_errors++; $display("FAIL reset_cfg ready=%b err=%b exp=1/0", cfg_ready, cfg_err);
    end
    rst = 1'b0;
    $display("reset: clk_out=%b tick=%b pend=%b", clk_out, tick, pend);
  endtask

  // Default T=1 TOGGLE on ch0: high,low,low,high,... and tick every second cycle.
  task automatic test_toggle();
    en = 3'b001;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      n_checks++;
      if (clk_out[0] !== ((k / 2) % 2 == 0)) begin
        n_errors++; $display("FAIL toggle_out k=%0d got=%b exp=%b", k, clk_out[0], ((k / 2) % 2 == 0));
      end
      n_checks++;
      if (tick[0] !== (k % 2 == 0)) begin
        n_errors++; $display("FAIL toggle_tick k=%0d got=%b exp=%b", k, tick[0], (k % 2 == 0));
      end
    end
    $display("toggle: ch0 12 cycles observed");
  endtask

  task automatic test_pulse_cfg();
    int waited;
    int highs;
    en = 3'b011;
    cyc(); cyc(); cyc();
    cfg_chan = 2'd1; cfg_div = 8'd4; cfg_mode = 1'b1; cfg_valid = 1'b1;
    #1;
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL pulse_ready_before got=%b exp=1", cfg_ready); end
    cyc();
    cfg_valid = 1'b0;
    n_checks++;
    if (pend[1] !== 1'b1 || cfg_ready !== 1'b0) begin
      n_errors++; $display("FAIL pulse_pend_set pend=%b ready=%b exp=1/0", pend[1], cfg_ready);
    end
    waited = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(); waited++;
      if (tick[1]) break;
      n_checks++;
      if (pend[1] !== 1'b1) begin n_errors++; $display("FAIL pulse_pend_hold got=%b exp=1", pend[1]); end
    end
    n_checks++;
    if (waited != 2 || tick[1] !== 1'b1) begin
      n_errors++; $display("FAIL pulse_apply_wrap waited=%0d tick=%b exp=2/1", waited, tick[1]);
    end
    n_checks++;
    if (pend[1] !== 1'b0 || clk_out[1] !== 1'b0) begin
      n_errors++; $display("FAIL pulse_apply pend=%b out=%b exp=0/0", pend[1], clk_out[1]);
    end
    highs = 0;
    for (int k = 0; k < 15; k++) begin
      cyc();
      if (clk_out[1]) highs++;
      n_checks++;
      if (clk_out[1] !== exp_out()[1] || tick[1] !== exp_tick()[1]) begin
        n_errors++; $display("FAIL pulse_model out=%b tick=%b exp=%b/%b", clk_out[1], tick[1], exp_out()[1], exp_tick()[1]);
      end
    end
    n_checks++;
    if (highs != 3) begin n_errors++; $display("FAIL pulse_highs got=%0d exp=3", highs); end
    $display("pulse_cfg: ch1 highs in 15 cycles=%0d", highs);
  endtask

  task automatic test_shrink();
    int  last;
    bit  prev, was_pend, applied;
    int  run;
    cfg_chan = 2'd2; cfg_div = 8'd3; cfg_mode = 1'b0; cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    cyc();
    n_checks++;
    if (pend[2] !== 1'b0) begin n_errors++; $display("FAIL shrink_apply_disabled got=%b exp=0", pend[2]); end
    en[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (tick[2]) break;
    end
    n_checks++;
    if (tick[2] !== 1'b1) begin n_errors++; $display("FAIL shrink_first_tick got=%b exp=1", tick[2]); end
    last = 0; prev = clk_out[2]; was_pend = 1'b0; applied = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (c == 2) begin cfg_chan = 2'd2; cfg_div = 8'd0; cfg_mode = 1'b0; cfg_valid = 1'b1; end
      cyc();
      cfg_valid = 1'b0;
      if (clk_out[2] !== prev) begin
        run = c - last;
        n_checks++;
        if (run != (applied ? 1 : 4)) begin
          n_errors++; $display("FAIL shrink_run c=%0d got=%0d exp=%0d", c, run, applied ? 1 : 4);
        end
        if (was_pend && !pend[2]) applied = 1'b1;
        last = c; prev = clk_out[2];
      end
      was_pend = pend[2];
    end
    n_checks++;
    if (!applied) begin n_errors++; $display("FAIL shrink_applied got=0 exp=1"); end
    $display("shrink: ch2 switched to T=0 applied=%0d", applied);
  endtask

  task automatic test_sync();
    int first0, first1;
    en = 3'b000;
    cfg_chan = 2'd0; cfg_div = 8'd2; cfg_mode = 1'b0; cfg_valid = 1'b1;
    cyc();
    cfg_chan = 2'd1; cfg_div = 8'd5;
    cyc();
    cfg_valid = 1'b0;
    cyc();
    n_checks++;
    if (pend !== 3'b000) begin n_errors++; $display("FAIL sync_setup_pend got=%b exp=000", pend); end
    en = 3'b011;
    repeat ($urandom_range(3, 20)) cyc();
    sync_in = 1'b1;
    cyc();
    sync_in = 1'b0;
    n_checks++;
    if (clk_out[1:0] !== 2'b11 || tick[1:0] !== 2'b00) begin
      n_errors++; $display("FAIL sync_idle out=%b tick=%b exp=11/00", clk_out[1:0], tick[1:0]);
    end
    first0 = -1; first1 = -1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (tick[0] && first0 < 0) first0 = k;
      if (tick[1] && first1 < 0) first1 = k;
    end
    n_checks++;
    if (first0 != 3 || first1 != 6) begin
      n_errors++; $display("FAIL sync_first_ticks got=%0d/%0d exp=3/6", first0, first1);
    end
    for (int k = 0; k < 10; k++) begin
      if (m_elapsed[0] == m_t[0]) break;
      cyc();
    end
    sync_in = 1'b1;
    cyc();
    sync_in = 1'b0;
    n_checks++;
    if (tick[0] !== 1'b0 || clk_out[0] !== 1'b1) begin
      n_errors++; $display("FAIL sync_on_wrap tick=%b out=%b exp=0/1", tick[0], clk_out[0]);
    end
    $display("sync: first ticks ch0=%0d ch1=%0d", first0, first1);
  endtask

  task automatic test_cfg_err();
    cfg_chan = 2'd3; cfg_div = 8'($urandom_range(0, 255)); cfg_mode = 1'b1; cfg_valid = 1'b1;
    #1;
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL err_ready got=%b exp=1", cfg_ready); end
    cyc();
    cfg_valid = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b1) begin n_errors++; $display("FAIL err_pulse got=%b exp=1", cfg_err); end
    n_checks++;
    if (pend !== exp_pend() || clk_out !== exp_out()) begin
      n_errors++; $display("FAIL err_no_effect pend=%b out=%b exp=%b/%b", pend, clk_out, exp_pend(), exp_out());
    end
    cyc();
    n_checks++;
    if (cfg_err !== 1'b0) begin n_errors++; $display("FAIL err_one_cycle got=%b exp=0", cfg_err); end
    $display("cfg_err: out-of-range request flagged");
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if (k % 8 == 0) en = NCH'($urandom);
      sync_in   = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_chan  = CW'($urandom_range(0, 3));
      cfg_div   = DW'($urandom_range(0, 6));
      cfg_mode  = 1'($urandom);
      #1;
      n_checks++;
      if (cfg_ready !== exp_ready()) begin
        n_errors++; $display("FAIL rand_ready k=%0d got=%b exp=%b", k, cfg_ready, exp_ready());
      end
      cyc();
      n_checks++;
      if (clk_out !== exp_out() || tick !== exp_tick() || pend !== exp_pend() || cfg_err !== m_err) begin
        n_errors++;
        $display("FAIL rand_outputs k=%0d out=%b tick=%b pend=%b err=%b exp=%b/%b/%b/%b",
                 k, clk_out, tick, pend, cfg_err, exp_out(), exp_tick(), exp_pend(), m_err);
      end
    end
    rst = 1'b0; sync_in = 1'b0; cfg_valid = 1'b0;
    $display("random: 400 cycles compared");
  endtask

  task automatic test_reset_mid();
    en = 3'b000;
    cfg_chan = 2'd0; cfg_div = 8'd50; cfg_mode = 1'b0; cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    cyc();
    en = 3'b001;
    repeat (5) cyc();
    cfg_div = 8'd9; cfg_mode = 1'b1; cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    n_checks++;
    if (pend[0] !== 1'b1) begin n_errors++; $display("FAIL rstmid_pend_before got=%b exp=1", pend[0]); end
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    n_checks++;
    if (clk_out !== 3'b111 || tick !== 3'b000 || pend !== 3'b000 || cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rstmid_values out=%b tick=%b pend=%b err=%b ready=%b exp=111/000/000/0/1",
               clk_out, tick, pend, cfg_err, cfg_ready);
    end
    rst = 1'b0;
    cyc();
    n_checks++;
    if (tick[0] !== 1'b0) begin n_errors++; $display("FAIL rstmid_tick1 got=%b exp=0", tick[0]); end
    cyc();
    n_checks++;
    if (tick[0] !== 1'b1 || clk_out[0] !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_default_div tick=%b out=%b exp=1/0", tick[0], clk_out[0]);
    end
    $display("reset_mid: defaults restored");
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_pulse_cfg();
    test_shrink();
    test_sync();
    test_cfg_err();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
